fcmp_pipe: RTL and testbench

FCMP_PIPE -- requirements
Module: fcmp_pipe

---
 rtl/fcmp_pipe.sv | 117 +++++++++++
 tb/tb_fcmp_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: pipelined floating-point compare / min / max.
// Result is computed combinationally from the operands and then carried through
// LAT register stages. A full-pipeline stall holds every stage.
// Optional feature: define FCMP_NAN_EXC_EN to raise exception on any NaN operand
// for ops 0..4. Without it, only reserved ops raise exception.
module fcmp_pipe #(
  parameter int EW  = 8,
  parameter int MW  = 23,
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic [EW+MW:0]   z,
  output logic             exception
);
  localparam int W      = 1 + EW + MW;
  localparam int EM     = EW + MW;
  localparam int STAGES = LAT - 1;

  // quiet NaN with only the top mantissa bit set; negative zero
  localparam logic [W-1:0] CNAN = {1'b0, {EW{1'b1}}, {MW{1'b0}}} | (W'(1) << (MW - 1));
  localparam logic [W-1:0] NEG0 = W'(1) << (W - 1);

  typedef struct packed {
    logic         y;
    logic [W-1:0] z;
    logic         exc;
  } res_t;

  // a < b in value order for non-NaN operands; +0 and -0 are equal
  function automatic logic lt_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [EM-1:0] ma, mb;
    ma = a[EM-1:0];
    mb = b[EM-1:0];
    if (ma == '0 && mb == '0) return 1'b0;
    if (a[W-1] != b[W-1])     return a[W-1];
    if (!a[W-1])              return ma < mb;
    return ma > mb;
  endfunction

  logic nan1, nan2, anynan, zz, lt12, lt21, eq, lt_ok;
  logic acc, stall;
  res_t res_c;

  logic [STAGES:0] vld_pipe;
  res_t [STAGES:0] dat_pipe;

  assign nan1   = (&x1[EM-1:MW]) && (|x1[MW-1:0]);
  assign nan2   = (&x2[EM-1:MW]) && (|x2[MW-1:0]);
  assign anynan = nan1 || nan2;
  assign zz     = (x1[EM-1:0] == '0) && (x2[EM-1:0] == '0);
  assign lt12   = lt_f(x1, x2);
  assign lt21   = lt_f(x2, x1);
  assign eq     = !anynan && ((x1 == x2) || zz);
  assign lt_ok  = !anynan && lt12;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign acc      = in_valid && in_ready;

  // result of the operation selected by op, before pipelining
  always_comb begin
    res_c = '0;
    case (op)
      3'd0: res_c.y = eq;
      3'd1: res_c.y = lt_ok;
      3'd2: res_c.y = lt_ok || eq;
      3'd3: begin
        if (nan1 && nan2) res_c.z = CNAN;
        else if (nan1)    res_c.z = x2;
        else if (nan2)    res_c.z = x1;
        else if (zz)      res_c.z = NEG0;
        else              res_c.z = lt21 ? x2 : x1;
      end
      3'd4: begin
        if (nan1 && nan2) res_c.z = CNAN;
        else if (nan1)    res_c.z = x2;
        else if (nan2)    res_c.z = x1;
        else if (zz)      res_c.z = '0;
        else              res_c.z = lt12 ? x2 : x1;
      end
      default: res_c.exc = 1'b1;
    endcase
`ifdef FCMP_NAN_EXC_EN
    if (op <= 3'd4 && anynan) res_c.exc = 1'b1;
`endif
  end

  // pipeline shift; empty slots carry a zero payload so idle outputs read 0
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (!stall) begin
      vld_pipe[0] <= acc;
      dat_pipe[0] <= acc ? res_c : '0;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign y         = dat_pipe[STAGES].y;
  assign z         = dat_pipe[STAGES].z;
  assign exception = dat_pipe[STAGES].exc;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: default instance (EW=8, MW=23, LAT=2) and a half-precision
// instance (EW=5, MW=10, LAT=1), both scored against a real-valued reference model.
module tb_fcmp_pipe;
`ifdef FCMP_NAN_EXC_EN
  localparam logic NEXC = 1'b1;
`else
  localparam logic NEXC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic iva, ira, ova, ora, ya, ea;
  logic [2:0] opa;
  logic [31:0] a1, a2, za;
  logic ivb, irb, ovb, orb, yb, eb;
  logic [2:0] opb;
  logic [15:0] b1, b2, zb;

  fcmp_pipe #(.EW(8), .MW(23), .LAT(2)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(iva), .in_ready(ira), .x1(a1), .x2(a2), .op(opa),
    .out_valid(ova), .out_ready(ora), .y(ya), .z(za), .exception(ea));

  fcmp_pipe #(.EW(5), .MW(10), .LAT(1)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(ivb), .in_ready(irb), .x1(b1), .x2(b2), .op(opb),
    .out_valid(ovb), .out_ready(orb), .y(yb), .z(zb), .exception(eb));

  typedef struct packed {
    logic        y;
    logic        e;
    logic [63:0] z;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int errors = 0;
  int checks = 0;
  int pops_a = 0;
  int pops_b = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic real p2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic logic is_nan(input logic [63:0] x, input int ew, input int mw);
    longint e = longint'((x >> mw) & ((64'd1 << ew) - 64'd1));
    longint m = longint'(x & ((64'd1 << mw) - 64'd1));
    return (e == (longint'(1) << ew) - 1) && (m != 0);
  endfunction

  // true numeric value; infinities map to +/-1e300, far beyond any finite value here
  function automatic real fval(input logic [63:0] x, input int ew, input int mw);
    int bias = (1 << (ew - 1)) - 1;
    longint e = longint'((x >> mw) & ((64'd1 << ew) - 64'd1));
    longint m = longint'(x & ((64'd1 << mw) - 64'd1));
    real v;
    if (e == (longint'(1) << ew) - 1) v = 1.0e300;
    else if (e == 0) v = real'(m) * p2(1 - bias - mw);
    else v = (real'(m) + p2(mw)) * p2(int'(e) - bias - mw);
    return x[ew+mw] ? -v : v;
  endfunction

  function automatic exp_t model(input int op, input logic [63:0] a, input logic [63:0] b,
                                 input int ew, input int mw);
    exp_t r;
    logic na, nb;
    real va, vb;
    logic [63:0] canon, negz;
    r = '0;
    na = is_nan(a, ew, mw);
    nb = is_nan(b, ew, mw);
    va = fval(a, ew, mw);
    vb = fval(b, ew, mw);
    canon = (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
    negz  = 64'd1 << (ew + mw);
    case (op)
      0: r.y = !na && !nb && (va == vb);
      1: r.y = !na && !nb && (va <  vb);
      2: r.y = !na && !nb && (va <= vb);
      3, 4: begin
        if (na && nb)         r.z = canon;
        else if (na)          r.z = b;
        else if (nb)          r.z = a;
        else if (va == vb)    r.z = (va == 0.0) ? ((op == 3) ? negz : 64'd0) : a;
        else                  r.z = ((va < vb) == (op == 3)) ? a : b;
      end
      default: r.e = 1'b1;
    endcase
    if (NEXC && op <= 4 && (na || nb)) r.e = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] gen(input int ew, input int mw);
    logic [63:0] s, e, m, emax, mmask;
    emax  = (64'd1 << ew) - 64'd1;
    mmask = (64'd1 << mw) - 64'd1;
    s = 64'($urandom_range(0, 1));
    m = {$urandom, $urandom} & mmask;
    case ($urandom_range(0, 5))
      0:       begin e = 64'd0; m = 64'd0; end
      1:       begin e = emax;  m = 64'd0; end
      2:       begin e = emax;  m = m | 64'd1; end
      3:       e = 64'd0;
      default: e = 64'($urandom_range(0, 32'(emax)));
    endcase
    return (s << (ew + mw)) | (e << mw) | m;
  endfunction

  // scoreboard for instance A: compare every cycle, then track the upcoming edge
  always @(negedge clk) begin
    exp_t f;
    if (ova) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 64'd1, 64'd0);
      else begin
        f = qa[0];
        chk("a_out", {30'b0, ya, ea, za}, {30'b0, f.y, f.e, f.z[31:0]});
      end
    end else chk("a_idle_zero", {30'b0, ya, ea, za}, 64'd0);
    chk("a_in_ready", 64'(ira), 64'(!(ova && !ora)));
    if (!rstn) qa.delete();
    else begin
      if (ova && ora && qa.size() > 0) begin void'(qa.pop_front()); pops_a++; end
      if (iva && ira) qa.push_back(model(int'(opa), {32'b0, a1}, {32'b0, a2}, 8, 23));
    end
  end

  // scoreboard for instance B
  always @(negedge clk) begin
    exp_t f;
    if (ovb) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 64'd1, 64'd0);
      else begin
        f = qb[0];
        chk("b_out", {46'b0, yb, eb, zb}, {46'b0, f.y, f.e, f.z[15:0]});
      end
    end else chk("b_idle_zero", {46'b0, yb, eb, zb}, 64'd0);
    chk("b_in_ready", 64'(irb), 64'(!(ovb && !orb)));
    if (!rstn) qb.delete();
    else begin
      if (ovb && orb && qb.size() > 0) begin void'(qb.pop_front()); pops_b++; end
      if (ivb && irb) qb.push_back(model(int'(opb), {48'b0, b1}, {48'b0, b2}, 5, 10));
    end
  end

  // present one transfer and hold it until accepted; entered and left at posedge+1
  task automatic push_a(input logic [2:0] op, input logic [31:0] x1, input logic [31:0] x2,
                        input bit rnd);
    int n = 0;
    bit acc = 1'b0;
    iva = 1'b1; opa = op; a1 = x1; a2 = x2;
    while (!acc) begin
      if (rnd) ora = ($urandom_range(0, 3) != 0);
      #1 acc = ira;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 50) begin chk("a_accept_timeout", 64'd0, 64'd1); acc = 1'b1; end
    end
    iva = 1'b0;
  endtask

  task automatic push_b(input logic [2:0] op, input logic [15:0] x1, input logic [15:0] x2,
                        input bit rnd);
    int n = 0;
    bit acc = 1'b0;
    ivb = 1'b1; opb = op; b1 = x1; b2 = x2;
    while (!acc) begin
      if (rnd) orb = ($urandom_range(0, 7) != 0);
      #1 acc = irb;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 50) begin chk("b_accept_timeout", 64'd0, 64'd1); acc = 1'b1; end
    end
    ivb = 1'b0;
  endtask

  // directed op on A with literal expectations and exact two-cycle latency
  task automatic dir_a(input string nm, input logic [2:0] op, input logic [31:0] x1,
                       input logic [31:0] x2, input logic ey, input logic [31:0] ez,
                       input logic ee);
    ora = 1'b1;
    push_a(op, x1, x2, 1'b0);
    @(negedge clk);
    chk({nm, "_early"}, 64'(ova), 64'd0);
    @(negedge clk);
    chk(nm, {29'b0, ova, ya, ea, za}, {29'b0, 1'b1, ey, ee, ez});
    @(posedge clk); #1;
  endtask

  task automatic dir_b(input string nm, input logic [2:0] op, input logic [15:0] x1,
                       input logic [15:0] x2, input logic ey, input logic [15:0] ez,
                       input logic ee);
    orb = 1'b1;
    push_b(op, x1, x2, 1'b0);
    @(negedge clk);
    chk(nm, {45'b0, ovb, yb, eb, zb}, {45'b0, 1'b1, ey, ee, ez});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  sop [8];
    logic [31:0] sx1 [8];
    logic [31:0] sx2 [8];
    logic [63:0] g1, g2;
    int idx, c, stall_seen, p0;
    bit acc;

    iva = 0; opa = 0; a1 = 0; a2 = 0; ora = 1;
    ivb = 0; opb = 0; b1 = 0; b2 = 0; orb = 1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_a", {28'b0, ira, ova, ya, ea, za}, {28'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    chk("rst_b", {44'b0, irb, ovb, yb, eb, zb}, {44'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    @(posedge clk); #1;

    dir_a("le_1_2",  3'd2, 32'h3F800000, 32'h40000000, 1'b1, 32'd0, 1'b0);
    dir_a("le_2_1",  3'd2, 32'h40000000, 32'h3F800000, 1'b0, 32'd0, 1'b0);
    dir_a("eq_zero", 3'd0, 32'h80000000, 32'h00000000, 1'b1, 32'd0, 1'b0);
    dir_a("min_zero",3'd3, 32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 1'b0);
    dir_a("max_zero",3'd4, 32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
    dir_a("lt_nan",  3'd1, 32'h7FC00001, 32'h3F800000, 1'b0, 32'd0, NEXC);
    dir_a("max_nan", 3'd4, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h3F800000, NEXC);
    dir_a("min_2nan",3'd3, 32'h7FC00001, 32'hFF800001, 1'b0, 32'h7FC00000, NEXC);
    dir_a("rsv_op6", 3'd6, 32'h3F800000, 32'h40000000, 1'b0, 32'd0, 1'b1);

    // back-to-back stream with a four-cycle downstream stall
    for (int i = 0; i < 8; i++) begin
      sop[i] = 3'($urandom_range(0, 4));
      g1 = gen(8, 23);
      g2 = ($urandom_range(0, 1) != 0) ? gen(8, 23) : g1;
      sx1[i] = g1[31:0];
      sx2[i] = g2[31:0];
    end
    idx = 0; c = 0; stall_seen = 0; p0 = pops_a;
    while (idx < 8 && c < 40) begin
      ora = !(c >= 3 && c <= 6);
      iva = 1'b1; opa = sop[idx]; a1 = sx1[idx]; a2 = sx2[idx];
      #1;
      if (!ora) begin
        stall_seen++;
        chk("a_stall_in_ready", 64'(ira), 64'd0);
      end
      acc = ira;
      @(posedge clk); #1;
      if (acc) idx++;
      c++;
    end
    iva = 1'b0; ora = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("a_stall_cycles", 64'(stall_seen), 64'd4);
    chk("a_stream_count", 64'(pops_a - p0), 64'd8);

    // reset with two undelivered results in flight
    ora = 1'b1;
    push_a(3'd2, 32'h3F800000, 32'h40000000, 1'b0);
    push_a(3'd0, 32'h40000000, 32'h40000000, 1'b0);
    ora = 1'b0; rstn = 1'b0;
    iva = 1'b1; opa = 3'd1; a1 = 32'h0; a2 = 32'h3F800000;
    @(posedge clk); #1;
    rstn = 1'b1; iva = 1'b0; ora = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("a_rst_flush", {31'b0, ova, ya, 31'b0, ea}, 64'd0);
    end
    @(posedge clk); #1;
    dir_a("rsv_op6_post", 3'd6, 32'h0, 32'h0, 1'b0, 32'd0, 1'b1);

    // randomized traffic on A
    for (int i = 0; i < 300; i++) begin
      g1 = gen(8, 23);
      g2 = ($urandom_range(0, 2) != 0) ? gen(8, 23) : (g1 ^ (64'($urandom_range(0, 1)) << 31));
      push_a(($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
             g1[31:0], g2[31:0], 1'b1);
    end
    ora = 1'b1;

    // half-precision instance: directed infinities, then full sign/exponent sweep
    dir_b("b_le_inf", 3'd2, 16'h7C00, 16'hFC00, 1'b0, 16'd0, 1'b0);
    dir_b("b_lt_inf", 3'd1, 16'hFC00, 16'h7C00, 1'b1, 16'd0, 1'b0);
    dir_b("b_max_nan", 3'd4, 16'h7E01, 16'h3C00, 1'b0, 16'h3C00, NEXC);
    for (int s1 = 0; s1 < 2; s1++)
      for (int e1 = 0; e1 < 32; e1++)
        for (int s2 = 0; s2 < 2; s2++)
          for (int e2 = 0; e2 < 32; e2++) begin
            logic [9:0] m1, m2;
            m1 = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom);
            case ($urandom_range(0, 2))
              0:       m2 = m1;
              1:       m2 = 10'd0;
              default: m2 = 10'($urandom);
            endcase
            push_b(3'($urandom_range(0, 4)), {1'(s1), 5'(e1), m1}, {1'(s2), 5'(e2), m2}, 1'b1);
          end
    orb = 1'b1;

    repeat (6) @(posedge clk);
    #1;
    chk("a_drain", 64'(qa.size()), 64'd0);
    chk("b_drain", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
